mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one Avalon-MM agent port (unified instruction/data memory) between two hosts: the instruction manager (read-only) and the data manager (read/write).
- Sits between the CPU front-end/LSU and the memory interconnect.
- Grants one host at a time, with round-robin priority.
- Allows a single outstanding transaction and routes the read response back to the host that issued it.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byteenable width = DATA_W/8)
- RESP_TIMEOUT, 255, max cycles to wait for readdatavalid after read accept; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_address  in  ADDR_W  instruction host address
- i_read  in  1  instruction host read request
- i_byteenable  in  DATA_W/8  instruction host byte enables
- i_waitrequest  out  1  instruction host stall
- i_readdata  out  DATA_W  instruction host read data
- i_readdatavalid  out  1  instruction host read data valid
- d_address  in  ADDR_W  data host address
- d_read  in  1  data host read request
- d_write  in  1  data host write request
- d_byteenable  in  DATA_W/8  data host byte enables
- d_writedata  in  DATA_W  data host write data
- d_waitrequest  out  1  data host stall
- d_readdata  out  DATA_W  data host read data
- d_readdatavalid  out  1  data host read data valid
- m_address  out  ADDR_W  agent address
- m_read  out  1  agent read
- m_write  out  1  agent write
- m_byteenable  out  DATA_W/8  agent byte enables
- m_writedata  out  DATA_W  agent write data
- m_waitrequest  in  1  agent stall
- m_readdata  in  DATA_W  agent read data
- m_readdatavalid  in  1  agent read data valid
- grant  out  2  {data, instr} one-hot owner, or 0 when idle
- bus_error  out  1  sticky protocol/timeout error flag

Behaviour:
- Reset: state=IDLE, grant=0, last_winner=DATA (so INSTR wins the first tie), timeout counter=0, bus_error=0.
  - All m_* outputs are 0; i/d_waitrequest=1; i/d_readdatavalid=0; i/d_readdata=0.
- Hosts follow Avalon-MM rules: hold a command stable until their waitrequest is low, then deassert.
- A non-granted host always sees waitrequest=1.
- Request is defined per host: i_req=i_read; d_req=d_read|d_write.
- State IDLE:
  - Sample requests.
  - If exactly one host requests, grant it.
  - If both request, grant the one that is not last_winner.
  - Register grant and last_winner, then go to CMD.
  - m_read/m_write=0 while in IDLE.
  - Arbitration latency is exactly 1 cycle: request seen at edge N gives m_read/m_write asserted after edge N+1.
- State CMD:
  - m_* signals are combinationally forwarded from the granted host.
  - The granted host's waitrequest equals m_waitrequest.
  - While m_waitrequest=1, stay in CMD.
  - On accept (m_waitrequest=0) with a write: go to IDLE.
  - On accept with a read: go to RESP and clear the timeout counter.
- State RESP:
  - m_read=m_write=0; both host waitrequests are 1.
  - When m_readdatavalid=1: forward m_readdata and a 1-cycle readdatavalid to the granted host (combinational pass-through), then go to IDLE.
  - Otherwise increment the timeout counter.
  - When the counter reaches RESP_TIMEOUT (if nonzero): drive the granted host's readdatavalid=1 with readdata=0, set bus_error, and go to IDLE.
- Zero-latency agent: m_readdatavalid in the same cycle as accept in CMD is delivered in that cycle, and the block goes straight to IDLE.
- Non-granted host readdata is held at 0.
- Stray m_readdatavalid in IDLE or on a write: ignored, and sets bus_error.
- d_read and d_write both high: treated as a write, and sets bus_error.
- Back-to-back: after IDLE returns, a host that just finished and re-requests loses to a pending other host.
  - Minimum one IDLE cycle between transactions.
- Reset mid-transaction: the command is abandoned and the state machine returns to IDLE.
  - A later response from the agent is stray and sets bus_error.
- bus_error is cleared only by rst.

Decomposition:
- Shared package Types gets:
  - enum arb_state_t {IDLE, CMD, RESP}
  - enum arb_owner_t {OWNER_INSTR, OWNER_DATA}
  - localparam defaults for ADDR_W and DATA_W
- One natural sub-module: rr_arbiter2. It is a two-requester round-robin picker, combinational from req[1:0] and last_winner, producing a one-hot grant.
- Muxing, the FSM and the timeout counter stay in mem_bus_arbiter.

Test Plan:
- Instruction read alone:
  - i_read=1 at addr 0x100; m_waitrequest=1 for 2 cycles, then 0.
  - m_read=1 and m_address=0x100 for 3 cycles; i_waitrequest drops on the 3rd.
  - After 2 more cycles, m_readdatavalid with m_readdata=0xdeadbeef gives i_readdatavalid=1 and i_readdata=0xdeadbeef for 1 cycle; grant returns to 0.
- Simultaneous requests:
  - i_read at 0x0 and d_write at 0x40 (data 0x12345678) arrive together after reset.
  - Instr is served first; then m_write=1, m_address=0x40, m_writedata=0x12345678 follow.
  - d_waitrequest stays 1 until the data grant.
- Fairness:
  - Both hosts request continuously for 4 transactions with zero-wait writes/reads.
  - Grant alternates INSTR, DATA, INSTR, DATA.
- Timeout (RESP_TIMEOUT=4):
  - Read is accepted and readdatavalid never comes.
  - On the 4th RESP cycle, the host gets readdatavalid=1 with readdata=0; bus_error=1; next state is IDLE.
- Reset mid-read:
  - rst=1 for 1 cycle while in RESP; m_readdatavalid arrives 2 cycles later.
  - No host readdatavalid is asserted; bus_error=1; grant=0.
- Illegal data command:
  - d_read=d_write=1 at 0x8.
  - m_write=1, m_read=0, bus_error=1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-host Avalon-MM memory arbiter.
// Holds the FSM state encoding, the bus-owner encoding and width defaults.
// Also provides a helper that turns an owner into a one-hot grant vector.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

  // Grant bit layout is {data, instr}
  function automatic logic [1:0] owner_onehot(input arb_owner_t owner);
    return (owner == OWNER_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker: req[0]=instr, req[1]=data.
// Purely combinational, zero latency; no backpressure of its own.
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_owner_t last_winner_i,
  output logic [1:0] gnt_o,
  output arb_owner_t winner_o
);

  // Pick a winner from the request pair, rotating priority on a tie
  always_comb begin
    winner_o = OWNER_INSTR;
    case (req_i)
      2'b01:   winner_o = OWNER_INSTR;
      2'b10:   winner_o = OWNER_DATA;
      2'b11:   winner_o = (last_winner_i == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
      default: winner_o = OWNER_INSTR;
    endcase
    gnt_o = (req_i == 2'b00) ? 2'b00 : owner_onehot(winner_o);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-MM agent between an instruction host and a data host.
// Latency: 1 IDLE cycle of arbitration, then commands forwarded combinationally.
// Backpressure: owner sees m_waitrequest in CMD; everyone else sees waitrequest=1.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  input  logic [DATA_W/8-1:0] i_byteenable,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  output logic [1:0]          grant,
  output logic                bus_error
);

  localparam int CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
  // The timeout fires in the cycle the counter shows RESP_TIMEOUT-1, i.e. the
  // RESP_TIMEOUT-th cycle spent waiting.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

  arb_state_t       state_q;
  arb_owner_t       owner_q;
  arb_owner_t       last_winner_q;
  logic [1:0]       grant_q;
  logic             bus_error_q;
  logic [CNT_W-1:0] resp_cnt_q;

  logic [1:0]  arb_gnt;
  arb_owner_t  arb_winner;

  logic in_cmd, in_resp, own_data;
  logic cmd_rd, cmd_wr, accept;
  logic rsp_ok, tmo_hit, rsp_fire, stray_rdv, err_d;

  rr_arbiter2 u_rr (
    .req_i         ({d_read | d_write, i_read}),
    .last_winner_i (last_winner_q),
    .gnt_o         (arb_gnt),
    .winner_o      (arb_winner)
  );

  // Decode the current command and the response/error events for this cycle
  always_comb begin
    in_cmd   = (state_q == CMD);
    in_resp  = (state_q == RESP);
    own_data = (owner_q == OWNER_DATA);
    // A data host asserting read and write together is serviced as a write
    cmd_wr   = own_data & d_write;
    cmd_rd   = own_data ? (d_read & ~d_write) : i_read;
    accept   = in_cmd & ~m_waitrequest;
    // Zero-latency agents may return data in the same cycle the read is accepted
    rsp_ok   = m_readdatavalid & (in_resp | (accept & cmd_rd));
    tmo_hit  = (RESP_TIMEOUT != 0) && in_resp && !m_readdatavalid && (resp_cnt_q == TMO_LAST);
    rsp_fire = rsp_ok | tmo_hit;
    stray_rdv = m_readdatavalid & ~(in_resp | (accept & cmd_rd));
    err_d    = stray_rdv | tmo_hit | (in_cmd & own_data & d_read & d_write);
  end

  // Forward the owner's command to the agent and route responses back
  always_comb begin
    m_read          = in_cmd & cmd_rd;
    m_write         = in_cmd & cmd_wr;
    m_address       = in_cmd ? (own_data ? d_address : i_address) : '0;
    m_byteenable    = in_cmd ? (own_data ? d_byteenable : i_byteenable) : '0;
    m_writedata     = (in_cmd & own_data) ? d_writedata : '0;
    i_waitrequest   = (in_cmd & ~own_data) ? m_waitrequest : 1'b1;
    d_waitrequest   = (in_cmd & own_data) ? m_waitrequest : 1'b1;
    i_readdatavalid = rsp_fire & ~own_data;
    d_readdatavalid = rsp_fire & own_data;
    // A timed-out read returns zero data
    i_readdata      = (rsp_ok & ~own_data) ? m_readdata : '0;
    d_readdata      = (rsp_ok & own_data) ? m_readdata : '0;
    grant           = grant_q;
    bus_error       = bus_error_q;
  end

  // Arbitration FSM with response timeout and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_INSTR;
      last_winner_q <= OWNER_DATA;
      grant_q       <= 2'b00;
      bus_error_q   <= 1'b0;
      resp_cnt_q    <= '0;
    end else begin
      if (err_d) bus_error_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            grant_q       <= arb_gnt;
            owner_q       <= arb_winner;
            last_winner_q <= arb_winner;
            state_q       <= CMD;
          end
        end
        CMD: begin
          if (accept) begin
            if (cmd_rd && !m_readdatavalid) begin
              state_q    <= RESP;
              resp_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        RESP: begin
          if (rsp_fire) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end else begin
            resp_cnt_q <= resp_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule
